daq_link_tx: RTL and testbench

DAQ_LINK_TX -- requirements
Module: daq_link_tx

---
 rtl/daq_link_pkg.sv | 26 ++
 rtl/daq_link_tx_if.sv | 21 ++
 rtl/daq_link_tx.sv | 138 +++++++++++++
 tb/tb_daq_link_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/daq_link_pkg.sv
// rtl/daq_link_pkg.sv - shared link constants and state encoding for DAQ transmit/receive paths
package daq_link_pkg;

  localparam logic [7:0]  K_IDLE    = 8'hBC;
  localparam logic [7:0]  K_SOE     = 8'hFB;
  localparam logic [7:0]  K_EOE     = 8'hFD;
  localparam logic [31:0] IDLE_WORD = {24'h505050, K_IDLE};
  localparam logic [3:0]  IS_K_B0   = 4'b0001;
  localparam logic [3:0]  IS_K_NONE = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOE     = 3'd1,
    ST_DATA    = 3'd2,
    ST_TRAILER = 3'd3,
    ST_EOE     = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_GAP     = 3'd6
  } state_t;

  // Folds both halves of a payload word into the running 16-bit event checksum.
  function automatic logic [15:0] csum_add(input logic [15:0] c, input logic [31:0] w);
    return c + w[31:16] + w[15:0];
  endfunction

endpackage

// File: rtl/daq_link_tx_if.sv
// rtl/daq_link_tx_if.sv - payload input handshake and link output bundle
interface daq_link_tx_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] link_data;
  logic [3:0]  link_is_k;
  logic        link_valid;

  // master: payload producer that also observes the link; slave: the transmitter.
  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, link_data, link_is_k, link_valid
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, link_data, link_is_k, link_valid
  );
endinterface

// File: rtl/daq_link_tx.sv
// rtl/daq_link_tx.sv - frames payload events into SOE/DATA/TRAILER/EOE link words
module daq_link_tx
  import daq_link_pkg::*;
#(
  parameter int IDLE_GAP = 4,
  parameter int MAX_LEN  = 2048
) (
  input  logic          clk_link,
  input  logic          reset_n,
  input  logic          enable,
  daq_link_tx_if.slave  bus,
  output logic [23:0]   evt_count,
  output logic [15:0]   trunc_count,
  output logic          busy
);

  localparam logic [11:0] LenLast = 12'(MAX_LEN - 1);
  // The IDLE state always contributes one idle word, so GAP covers the rest.
  localparam state_t      PostEvt = (IDLE_GAP > 1) ? ST_GAP : ST_IDLE;
  localparam logic [3:0]  GapLoad = (IDLE_GAP > 1) ? 4'(IDLE_GAP - 2) : 4'd0;

  state_t      state, state_d;
  logic [11:0] len;
  logic [15:0] csum;
  logic        trunc;
  logic [3:0]  gap_cnt;

  logic        in_ready_q;
  logic [31:0] link_data_q;
  logic [3:0]  link_is_k_q;
  logic        link_valid_q;

  logic [31:0] word_d;
  logic [3:0]  is_k_d;
  logic        ready_d;
  logic        busy_d;

  logic accept;
  logic at_max;

  assign accept = bus.in_valid && in_ready_q;
  assign at_max = (len == LenLast);

  assign bus.in_ready   = in_ready_q;
  assign bus.link_data  = link_data_q;
  assign bus.link_is_k  = link_is_k_q;
  assign bus.link_valid = link_valid_q;

  always_ff @(posedge clk_link) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:    if (enable && bus.in_valid) state_d = ST_SOE;
      ST_SOE:     state_d = ST_DATA;
      ST_DATA:    if (accept && (bus.in_last || at_max)) state_d = ST_TRAILER;
      ST_TRAILER: state_d = ST_EOE;
      ST_EOE:     state_d = trunc ? ST_DRAIN : PostEvt;
      ST_DRAIN:   if (accept && bus.in_last) state_d = PostEvt;
      ST_GAP:     if (gap_cnt == 4'd0) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    word_d = IDLE_WORD;
    is_k_d = IS_K_B0;
    case (state)
      ST_SOE: word_d = {evt_count, K_SOE};
      ST_DATA: begin
        if (accept) begin
          word_d = bus.in_data;
          is_k_d = IS_K_NONE;
        end
      end
      ST_TRAILER: begin
        word_d = {trunc, 3'b000, len, csum};
        is_k_d = IS_K_NONE;
      end
      ST_EOE: word_d = {evt_count, K_EOE};
      default: ;
    endcase
    ready_d = (state_d == ST_DATA) || (state_d == ST_DRAIN);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_link) begin
    if (!reset_n) begin
      link_data_q  <= '0;
      link_is_k_q  <= '0;
      link_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      busy         <= 1'b0;
      evt_count    <= '0;
      trunc_count  <= '0;
      len          <= '0;
      csum         <= '0;
      trunc        <= 1'b0;
      gap_cnt      <= '0;
    end else begin
      link_data_q  <= word_d;
      link_is_k_q  <= is_k_d;
      link_valid_q <= 1'b1;
      in_ready_q   <= ready_d;
      busy         <= busy_d;

      if (state == ST_SOE) begin
        len   <= '0;
        csum  <= '0;
        trunc <= 1'b0;
      end

      if (state == ST_DATA && accept) begin
        len  <= len + 12'd1;
        csum <= csum_add(csum, bus.in_data);
        if (at_max && !bus.in_last) trunc <= 1'b1;
      end

      if (state == ST_EOE) begin
        evt_count <= evt_count + 24'd1;
        if (trunc && trunc_count != 16'hFFFF) trunc_count <= trunc_count + 16'd1;
      end

      if (state_d == ST_GAP && state != ST_GAP) begin
        gap_cnt <= GapLoad;
      end else if (state == ST_GAP) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_daq_link_tx.sv
// tb/tb_daq_link_tx.sv - directed scoreboard bench for daq_link_tx
module tb_daq_link_tx;

  localparam logic [31:0] IDLE_W = 32'h505050BC;

  logic        clk_link = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [23:0] evt_count;
  logic [15:0] trunc_count;
  logic        busy;

  daq_link_tx_if bus ();

  daq_link_tx #(.IDLE_GAP(4), .MAX_LEN(4)) dut (
    .clk_link    (clk_link),
    .reset_n     (reset_n),
    .enable      (enable),
    .bus         (bus),
    .evt_count   (evt_count),
    .trunc_count (trunc_count),
    .busy        (busy)
  );

  always #5 clk_link = ~clk_link;

  int          n_pass;
  int          n_total;
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];
  bit          cap_en;
  logic [23:0] exp_evt;
  logic [11:0] b_len;
  logic [15:0] b_csum;

  always @(posedge clk_link) begin
    #1;
    if (cap_en) got_q.push_back({bus.link_is_k, bus.link_data});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push_k(input logic [31:0] d, input logic [3:0] k);
    exp_q.push_back({k, d});
  endtask

  task automatic push_idles(input int n);
    for (int i = 0; i < n; i++) push_k(IDLE_W, 4'b0001);
  endtask

  task automatic start_event();
    push_k({exp_evt, 8'hFB}, 4'b0001);
    b_len  = '0;
    b_csum = '0;
  endtask

  task automatic end_event(input logic tr);
    push_k({tr, 3'b000, b_len, b_csum}, 4'b0000);
    push_k({exp_evt, 8'hFD}, 4'b0001);
    exp_evt = exp_evt + 24'd1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input bit xmit, output bit ok);
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    if (xmit) begin
      exp_q.push_back({4'b0000, d});
      b_len  = b_len + 12'd1;
      b_csum = b_csum + d[31:16] + d[15:0];
    end
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.in_ready === 1'b1) ok = 1'b1;
      @(negedge clk_link);
    end
  endtask

  task automatic check_stream(input string tag);
    logic [35:0] e;
    logic [35:0] g;
    while (got_q.size() > 0 && got_q[0] === {4'b0001, IDLE_W}) g = got_q.pop_front();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front();
      else g = 'x;
      chk(tag, 64'(g), 64'(e));
    end
    got_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit ok;
    int bad;
    n_pass  = 0;
    n_total = 0;
    cap_en  = 1'b0;
    exp_evt = '0;
    reset_n = 1'b0;
    enable  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    repeat (3) @(negedge clk_link);
    chk("rst_link_data",  64'(bus.link_data), 64'(0));
    chk("rst_link_is_k",  64'(bus.link_is_k), 64'(0));
    chk("rst_link_valid", 64'(bus.link_valid), 64'(0));
    chk("rst_in_ready",   64'(bus.in_ready), 64'(0));
    chk("rst_busy",       64'(busy), 64'(0));
    chk("rst_evt_count",  64'(evt_count), 64'(0));
    chk("rst_trunc",      64'(trunc_count), 64'(0));

    reset_n = 1'b1;
    @(negedge clk_link);
    chk("first_idle_data",  64'(bus.link_data), 64'(IDLE_W));
    chk("first_idle_is_k",  64'(bus.link_is_k), 64'(4'b0001));
    chk("first_idle_valid", 64'(bus.link_valid), 64'(1));

    bus.in_valid = 1'b1;
    bus.in_data  = 32'h00010002;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_link);
      chk("dis_in_ready", 64'(bus.in_ready), 64'(0));
      chk("dis_busy",     64'(busy), 64'(0));
      chk("dis_idle",     64'(bus.link_data), 64'(IDLE_W));
    end

    got_q.delete();
    cap_en = 1'b1;
    enable = 1'b1;
    start_event();
    send_word(32'h00010002, 1'b0, 1'b1, ok); chk("e1_acc1", 64'(ok), 64'(1));
    chk("e1_busy", 64'(busy), 64'(1));
    send_word(32'h00030004, 1'b0, 1'b1, ok); chk("e1_acc2", 64'(ok), 64'(1));
    send_word(32'h00050006, 1'b1, 1'b1, ok); chk("e1_acc3", 64'(ok), 64'(1));
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    end_event(1'b0);
    push_idles(4);
    repeat (12) @(negedge clk_link);
    cap_en = 1'b0;
    check_stream("e1_stream");
    chk("e1_evt_count", 64'(evt_count), 64'(1));
    chk("e1_trunc",     64'(trunc_count), 64'(0));

    cap_en = 1'b1;
    start_event();
    send_word(32'h11112222, 1'b0, 1'b1, ok); chk("gap_acc1", 64'(ok), 64'(1));
    bus.in_valid = 1'b0;
    push_idles(1);
    @(negedge clk_link);
    send_word(32'h33334444, 1'b1, 1'b1, ok); chk("gap_acc2", 64'(ok), 64'(1));
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    end_event(1'b0);
    repeat (12) @(negedge clk_link);
    cap_en = 1'b0;
    check_stream("gap_stream");
    chk("gap_evt_count", 64'(evt_count), 64'(2));

    cap_en = 1'b1;
    start_event();
    send_word(32'hAAAA0001, 1'b0, 1'b1, ok); chk("rst_acc1", 64'(ok), 64'(1));
    send_word(32'hAAAA0002, 1'b0, 1'b1, ok); chk("rst_acc2", 64'(ok), 64'(1));
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk_link);
    cap_en = 1'b0;
    check_stream("rst_pre_stream");
    exp_evt = '0;
    @(negedge clk_link);
    chk("mid_rst_data",     64'(bus.link_data), 64'(0));
    chk("mid_rst_valid",    64'(bus.link_valid), 64'(0));
    chk("mid_rst_busy",     64'(busy), 64'(0));
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("mid_rst_evt",      64'(evt_count), 64'(0));
    reset_n = 1'b1;
    got_q.delete();
    cap_en = 1'b1;
    repeat (8) @(negedge clk_link);
    cap_en = 1'b0;
    bad = 0;
    foreach (got_q[i]) if (got_q[i] !== {4'b0001, IDLE_W}) bad++;
    chk("post_rst_words",     64'(got_q.size()), 64'(8));
    chk("post_rst_idle_only", 64'(bad), 64'(0));
    chk("post_rst_evt",       64'(evt_count), 64'(0));
    got_q.delete();

    cap_en = 1'b1;
    start_event();
    send_word(32'h0A0A0001, 1'b0, 1'b1, ok); chk("b2b_acc1", 64'(ok), 64'(1));
    send_word(32'h0A0A0002, 1'b1, 1'b1, ok); chk("b2b_acc2", 64'(ok), 64'(1));
    end_event(1'b0);
    push_idles(4);
    start_event();
    send_word(32'h0B0B0001, 1'b0, 1'b1, ok); chk("b2b_acc3", 64'(ok), 64'(1));
    send_word(32'h0B0B0002, 1'b1, 1'b1, ok); chk("b2b_acc4", 64'(ok), 64'(1));
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    end_event(1'b0);
    repeat (12) @(negedge clk_link);
    cap_en = 1'b0;
    check_stream("b2b_stream");
    chk("b2b_evt_count", 64'(evt_count), 64'(2));

    cap_en = 1'b1;
    start_event();
    for (int i = 1; i <= 4; i++) begin
      send_word({16'(i), 16'(i)}, 1'b0, 1'b1, ok);
      chk("tr_acc", 64'(ok), 64'(1));
    end
    end_event(1'b1);
    send_word(32'hDEAD0005, 1'b0, 1'b0, ok); chk("tr_drain5", 64'(ok), 64'(1));
    send_word(32'hDEAD0006, 1'b1, 1'b0, ok); chk("tr_drain6", 64'(ok), 64'(1));
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    push_idles(4);
    repeat (12) @(negedge clk_link);
    cap_en = 1'b0;
    check_stream("tr_stream");
    chk("tr_trunc_count", 64'(trunc_count), 64'(1));
    chk("tr_evt_count",   64'(evt_count), 64'(3));

    cap_en = 1'b1;
    start_event();
    for (int i = 1; i <= 4; i++) begin
      send_word(32'hFFFFFFFF, (i == 4), 1'b1, ok);
      chk("max_acc", 64'(ok), 64'(1));
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    end_event(1'b0);
    push_idles(4);
    repeat (12) @(negedge clk_link);
    cap_en = 1'b0;
    check_stream("max_stream");
    chk("max_trunc_count", 64'(trunc_count), 64'(1));
    chk("max_evt_count",   64'(evt_count), 64'(4));
    chk("max_idle_busy",   64'(busy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
